// File: rtl/response_judge.sv
// Compares the player's actions against the queued display sequence and keeps score, lives and level.
// pass/fail pulse one cycle after the deciding act/tick; there is no backpressure, strobes are sampled once.
module response_judge #(
  parameter int DEPTH         = 16,
  parameter int TIMEOUT_TICKS = 6,
  parameter int START_LIVES   = 3
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_exp_valid,
  input  logic [2:0] i_exp_code,
  input  logic       i_seq_done,
  input  logic       i_act_valid,
  input  logic [2:0] i_act_code,
  input  logic       i_tick,
  output logic       o_busy,
  output logic       o_pass,
  output logic       o_fail,
  output logic [7:0] o_score,
  output logic [2:0] o_lives,
  output logic [7:0] o_level,
  output logic       o_overflow,
  output logic       o_game_over
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [2:0] {S_LOAD, S_JUDGE, S_PASS, S_FAIL, S_OVER} state_t;

  state_t        r_state;
  logic [2:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [TW-1:0] r_tcnt;
  logic [7:0]    r_score;
  logic [7:0]    r_level;
  logic [2:0]    r_lives;
  logic          r_overflow;
  logic          r_busy;
  logic          r_pass;
  logic          r_fail;
  logic          r_game_over;

  logic          w_exp_ok;
  logic          w_act_ok;
  logic          w_full;
  logic          w_push;
  logic [2:0]    w_head;
  logic          w_match;
  logic [TW-1:0] w_tcnt_inc;

  assign w_exp_ok   = (i_exp_code != 3'd0) && (i_exp_code <= 3'd4);
  assign w_act_ok   = i_act_valid && (i_act_code != 3'd0) && (i_act_code <= 3'd4);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_push     = !i_reset && (r_state == S_LOAD) && i_exp_valid && w_exp_ok && !w_full;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_match    = w_act_ok && (i_act_code == w_head);
  assign w_tcnt_inc = r_tcnt + TW'(1);

  // Storage is never reset; r_count alone decides which entries are live.
  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_exp_code;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_LOAD;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_tcnt      <= '0;
      r_score     <= 8'd0;
      r_level     <= 8'd0;
      r_lives     <= 3'(START_LIVES);
      r_overflow  <= 1'b0;
      r_busy      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_pass <= 1'b0;
      r_fail <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (i_exp_valid && w_exp_ok && w_full) r_overflow <= 1'b1;
          if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            r_count  <= r_count + CW'(1);
          end
          // seq_done sees the count after any same-cycle push
          if (i_seq_done && ((r_count != '0) || w_push)) begin
            r_state <= S_JUDGE;
            r_busy  <= 1'b1;
            r_tcnt  <= '0;
          end
        end
        S_JUDGE: begin
          if (w_act_ok) begin
            r_tcnt <= '0;
            if (w_match) begin
              r_rd_ptr <= r_rd_ptr + AW'(1);
              r_count  <= r_count - CW'(1);
              if (r_score != 8'hFF) r_score <= r_score + 8'd1;
              if (r_count == CW'(1)) begin
                r_state <= S_PASS;
                r_busy  <= 1'b0;
                r_pass  <= 1'b1;
                if (r_level != 8'hFF) r_level <= r_level + 8'd1;
              end
            end else begin
              r_state  <= S_FAIL;
              r_busy   <= 1'b0;
              r_fail   <= 1'b1;
              r_rd_ptr <= '0;
              r_wr_ptr <= '0;
              r_count  <= '0;
              r_lives  <= r_lives - 3'd1;
            end
          end else if (i_tick) begin
            if (w_tcnt_inc == TW'(TIMEOUT_TICKS)) begin
              r_state  <= S_FAIL;
              r_busy   <= 1'b0;
              r_fail   <= 1'b1;
              r_rd_ptr <= '0;
              r_wr_ptr <= '0;
              r_count  <= '0;
              r_tcnt   <= '0;
              r_lives  <= r_lives - 3'd1;
            end else begin
              r_tcnt <= w_tcnt_inc;
            end
          end
        end
        S_PASS: r_state <= S_LOAD;
        S_FAIL: begin
          if (r_lives == 3'd0) begin
            r_state     <= S_OVER;
            r_game_over <= 1'b1;
          end else begin
            r_state <= S_LOAD;
          end
        end
        S_OVER:  r_state <= S_OVER;
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_pass      = r_pass;
  assign o_fail      = r_fail;
  assign o_score     = r_score;
  assign o_lives     = r_lives;
  assign o_level     = r_level;
  assign o_overflow  = r_overflow;
  assign o_game_over = r_game_over;

endmodule

// File: doc/response_judge.md
RESPONSE_JUDGE -- requirements
Module: response_judge

Interface
REQ-001 Parameter DEPTH, default 16: expected-action FIFO entries, power of two.
REQ-002 Parameter TIMEOUT_TICKS, default 6: tick pulses allowed per expected action.
REQ-003 Parameter START_LIVES, default 3: lives loaded at reset; range 1..7.
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  reset is synchronous and active-high.
REQ-006 exp_valid  in  1  one-cycle strobe: display stage presents an action.
REQ-007 exp_code  in  3  displayed action: 1 toggle, 2 push, 3 mic, 4 mouse.
REQ-008 seq_done  in  1  one-cycle strobe: display stage finished the sequence.
REQ-009 act_valid  in  1  one-cycle strobe: player input detected.
REQ-010 act_code  in  3  player action, same encoding as exp_code.
REQ-011 tick  in  1  one-cycle timebase enable from the rate divider.
REQ-012 busy  out  1  high in JUDGE.
REQ-013 pass  out  1  one-cycle pulse: whole sequence matched.
REQ-014 fail  out  1  one-cycle pulse: mismatch or timeout.
REQ-015 score  out  8  count of correct actions, saturating.
REQ-016 lives  out  3  remaining lives.
REQ-017 level  out  8  count of passed sequences, saturating.
REQ-018 overflow  out  1  sticky: an expected action was dropped.
REQ-019 game_over  out  1  high in OVER.

Function
REQ-020 States: LOAD, JUDGE, PASS, FAIL, OVER; reset enters LOAD.
REQ-021 LOAD: exp_valid with exp_code in 1..4 pushes the code into the FIFO the same edge; codes 0, 5..7 ignored.
REQ-022 Push when FIFO holds DEPTH entries: entry dropped, FIFO unchanged, overflow set.
REQ-023 LOAD: seq_done with FIFO non-empty -> JUDGE next cycle; seq_done with FIFO empty ignored.
REQ-024 LOAD: exp_valid and seq_done in the same cycle: push first, then seq_done evaluated against the post-push count.
REQ-025 JUDGE: exp_valid and seq_done ignored; act_valid and tick ignored in every other state.
REQ-026 JUDGE: act_valid with act_code outside 1..4 ignored.
REQ-027 JUDGE: act_valid with act_code equal to FIFO head -> pop, score+1 (hold at 255), timeout counter cleared.
REQ-028 Match that empties the FIFO -> PASS next cycle.
REQ-029 JUDGE: act_valid with act_code in 1..4 not equal to head -> FAIL next cycle.
REQ-030 JUDGE: each tick without act_valid increments the timeout counter; reaching TIMEOUT_TICKS -> FAIL next cycle.
REQ-031 act_valid and tick in the same cycle: act_valid wins, tick discarded, counter cleared.
REQ-032 Timeout counter cleared on entry to JUDGE.
REQ-033 PASS: pass=1 for exactly one cycle, level+1 (hold at 255), -> LOAD.
REQ-034 FAIL: fail=1 for exactly one cycle, FIFO flushed, lives-1; new lives 0 -> OVER, else -> LOAD.
REQ-035 OVER: game_over=1, all inputs ignored, exit only by reset.
REQ-036 Latency: act_valid at edge N -> pass/fail high in cycle N+1.
REQ-037 overflow clears only on reset.

Reset
REQ-038 reset high at a rising edge: state LOAD, FIFO empty, timeout counter 0, score 0, level 0, lives START_LIVES, overflow 0, pass/fail/busy/game_over 0.
REQ-039 Reset overrides every other input in the same cycle, from any state, mid-sequence included.

Verification
REQ-040 Push 2,3,1, seq_done; act 2,3,1 -> score 3, pass pulse 1 cycle after final act, level 1, state LOAD.
REQ-041 Push 1,4, seq_done; act 1 then 2 -> score 1, fail pulse, lives 2, FIFO empty, state LOAD.
REQ-042 Push 3, seq_done; 6 ticks with no act -> fail on the cycle after 6th tick, lives START_LIVES-1.
REQ-043 Push 17 codes of 1 (DEPTH=16) -> overflow 1, 16 entries; 16 correct acts -> pass, score 16.
REQ-044 Three consecutive failures from lives=3 -> lives 0, game_over 1; further acts/seq_done no effect; reset -> lives 3, score 0.
REQ-045 In JUDGE, act_valid (correct) coincident with 6th tick -> match accepted, no fail, counter 0.
